// File: rtl/corr_pair_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : corr_pair_sequencer_if
//  Purpose  : Sample-load and pair-stream bundle of the correlation sequencer.
//  Revision : 1.0
// ============================================================================
interface corr_pair_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 13,
  parameter int LAG_W  = 13
);
  logic              wr_en;
  logic              wr_sel;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [LAG_W-1:0]  out_lag;
  logic              out_first;
  logic              out_last;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, out_ready,
    input  busy, done, out_valid, out_a, out_b, out_lag, out_first, out_last
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, out_ready,
    output busy, done, out_valid, out_a, out_b, out_lag, out_first, out_last
  );
endinterface
`default_nettype wire

// File: rtl/corr_pair_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : corr_pair_sequencer
//  Purpose  : Streams every (A[i], B[i+lag]) pair over all lags with backpressure.
//             Define CORR_WRAP_EN for circular (wrap-around) correlation.
//  Revision : 1.0
// ============================================================================
module corr_pair_sequencer #(
  parameter int DATA_W = 8,
  parameter int LEN_A  = 20,
  parameter int LEN_B  = 5000,
  parameter int AW     = 13,
  parameter int LAG_W  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  corr_pair_sequencer_if.slave  bus
);

  localparam int c_aw_a = (LEN_A > 1) ? $clog2(LEN_A) : 1;
  localparam int c_aw_b = (LEN_B > 1) ? $clog2(LEN_B) : 1;
  localparam logic [AW:0]   c_len_a  = (AW+1)'(LEN_A);
  localparam logic [AW:0]   c_len_b  = (AW+1)'(LEN_B);
  localparam logic [AW-1:0] c_last_i = AW'(LEN_A - 1);
`ifdef CORR_WRAP_EN
  localparam logic [AW-1:0] c_lag_max = AW'(LEN_B - 1);
`else
  localparam logic [AW-1:0] c_lag_max = AW'(LEN_B - LEN_A);
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_ram_a [LEN_A];
  logic [DATA_W-1:0] r_ram_b [LEN_B];
  logic [AW-1:0]     r_i;
  logic [AW-1:0]     r_lag;
  logic              r_exhausted;
  logic              r_busy;
  logic              r_done;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_a;
  logic [DATA_W-1:0] r_out_b;
  logic [LAG_W-1:0]  r_out_lag;
  logic              r_out_first;
  logic              r_out_last;

  logic [AW:0]       w_sum;
  logic [AW:0]       w_idx;
  logic              w_idx_ok;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_load;
  logic              w_accept;
  logic              w_wr;
  logic              w_wr_a_ok;
  logic              w_wr_b_ok;

  assign w_sum = {1'b0, r_i} + {1'b0, r_lag};
`ifdef CORR_WRAP_EN
  assign w_idx = (w_sum >= c_len_b) ? (w_sum - c_len_b) : w_sum;
`else
  assign w_idx = w_sum;
`endif
  // The guard is structurally true for legal parameters; it keeps the RAM read in range.
  assign w_idx_ok = (w_idx < c_len_b);
  assign w_rd_b   = w_idx_ok ? r_ram_b[w_idx[c_aw_b-1:0]] : '0;

  assign w_load   = (r_state == ST_RUN) && !r_exhausted && (!r_out_valid || bus.out_ready);
  assign w_accept = r_out_valid && bus.out_ready;

  assign w_wr      = !rst && (r_state == ST_IDLE) && bus.wr_en;
  assign w_wr_a_ok = !bus.wr_sel && ({1'b0, bus.wr_addr} < c_len_a);
  assign w_wr_b_ok =  bus.wr_sel && ({1'b0, bus.wr_addr} < c_len_b);

  // Sample RAMs carry no reset so their contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr && w_wr_a_ok) r_ram_a[bus.wr_addr[c_aw_a-1:0]] <= bus.wr_data;
    if (w_wr && w_wr_b_ok) r_ram_b[bus.wr_addr[c_aw_b-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_i         <= '0;
      r_lag       <= '0;
      r_exhausted <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_lag   <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
            r_i         <= '0;
            r_lag       <= '0;
            r_exhausted <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_a     <= r_ram_a[r_i[c_aw_a-1:0]];
            r_out_b     <= w_rd_b;
            r_out_lag   <= LAG_W'(r_lag);
            r_out_first <= (r_i == '0);
            r_out_last  <= (r_i == c_last_i);
            if (r_i == c_last_i) begin
              r_i <= '0;
              if (r_lag == c_lag_max) r_exhausted <= 1'b1;
              else                    r_lag       <= r_lag + 1'b1;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else if (w_accept) begin
            // Only reachable once every pair is loaded: this accept retires the final pair.
            r_out_valid <= 1'b0;
            if (r_exhausted) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out_valid = r_out_valid;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_lag   = r_out_lag;
  assign bus.out_first = r_out_first;
  assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire
